// File: rtl/aidc_lite_pkg.sv
// Shared definitions for the AIDC-lite concatenation scheduler.
// Holds the scheduler state encoding, the default block geometry
// (beat width, maximum compressed block size, preloaded prefix) and the
// widths of the size/bit-count fields.
package aidc_lite_pkg;

  localparam int DEF_DATA_SIZE   = 66;
  localparam int DEF_MAX_BITS    = 512;
  localparam int DEF_PREFIX_BITS = 2;

  // Bit-count accumulator and per-beat size field widths.
  localparam int ACC_W  = 11;
  localparam int SIZE_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_SINK = 2'd2
  } state_t;

endpackage

// File: rtl/aidc_lite_concat_sched.sv
// aidc_lite_concat_sched
// Block-granular round-robin scheduler between two code-beat requesters
// feeding one concatenation unit. A grant lasts from the first accepted
// beat to the eop beat. Each block's bit count (prefix included) is
// tracked. A block that grows past MAX_BITS is cut short on the cc side,
// its remaining beats are drained, and it is flagged for raw fallback.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid_i[1:0]  per-requester beat valid
//   req_ready_o[1:0]  per-requester beat accept (granted requester only)
//   req_sop_i/eop_i   per-requester block start/end markers
//   req_data_i[2]     per-requester beat data, MSB-aligned
//   req_size_i[2]     per-requester valid bits in beat (0..66)
//   cc_valid/sop/eop/data/size_o  registered beat to concatenation unit
//   cmpl_valid_o      one-cycle block completion pulse
//   cmpl_id_o         requester that owned the completed block
//   cmpl_bits_o       final block size in bits
//   cmpl_ovf_o        block overflowed MAX_BITS
module aidc_lite_concat_sched
  import aidc_lite_pkg::*;
#(
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int MAX_BITS    = DEF_MAX_BITS,
  parameter int PREFIX_BITS = DEF_PREFIX_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0]           req_sop_i,
  input  logic [1:0]           req_eop_i,
  input  logic [DATA_SIZE-1:0] req_data_i [2],
  input  logic [SIZE_W-1:0]    req_size_i [2],
  output logic                 cc_valid_o,
  output logic                 cc_sop_o,
  output logic                 cc_eop_o,
  output logic [DATA_SIZE-1:0] cc_data_o,
  output logic [SIZE_W-1:0]    cc_size_o,
  output logic                 cmpl_valid_o,
  output logic                 cmpl_id_o,
  output logic [ACC_W-1:0]     cmpl_bits_o,
  output logic                 cmpl_ovf_o
);

  localparam logic [ACC_W-1:0] PREFIX_INIT = ACC_W'(PREFIX_BITS);
  localparam logic [ACC_W-1:0] MAX_LIM     = ACC_W'(MAX_BITS);

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 rr_q, rr_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 first_q, first_d;

  logic                 cc_valid_d, cc_sop_d, cc_eop_d;
  logic [DATA_SIZE-1:0] cc_data_d;
  logic [SIZE_W-1:0]    cc_size_d;
  logic                 cmpl_valid_d, cmpl_id_d, cmpl_ovf_d;
  logic [ACC_W-1:0]     cmpl_bits_d;

  logic                 pick;
  logic                 sel_valid, sel_eop;
  logic [DATA_SIZE-1:0] sel_data;
  logic [SIZE_W-1:0]    sel_size;
  logic [ACC_W-1:0]     sum;

  // The first accepted beat of a grant always opens a cc block, so the
  // requester's own sop marker carries no information here.
  logic sop_unused;
  assign sop_unused = ^req_sop_i;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    first_d      = first_q;
    cc_valid_d   = 1'b0;
    cc_sop_d     = 1'b0;
    cc_eop_d     = 1'b0;
    cc_data_d    = '0;
    cc_size_d    = '0;
    cmpl_valid_d = 1'b0;
    cmpl_id_d    = 1'b0;
    cmpl_bits_d  = '0;
    cmpl_ovf_d   = 1'b0;
    req_ready_o  = 2'b00;
    pick         = 1'b0;

    sel_valid = req_valid_i[grant_q];
    sel_eop   = req_eop_i[grant_q];
    sel_data  = req_data_i[grant_q];
    sel_size  = req_size_i[grant_q];
    sum       = acc_q + {{(ACC_W-SIZE_W){1'b0}}, sel_size};

    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          // Contest goes to the rr pointer; a lone requester wins outright.
          pick     = (&req_valid_i) ? rr_q : req_valid_i[1];
          grant_d  = pick;
          rr_d     = ~pick;
          acc_d    = PREFIX_INIT;
          ovf_d    = 1'b0;
          first_d  = 1'b1;
          state_d  = ST_XFER;
        end
      end

      ST_XFER: begin
        req_ready_o[grant_q] = 1'b1;
        if (sel_valid) begin
          cc_valid_d = 1'b1;
          cc_sop_d   = first_q;
          cc_data_d  = sel_data;
          cc_size_d  = sel_size;
          first_d    = 1'b0;
          if (sum > MAX_LIM) begin
            // Overflowing beat still closes the cc block so the
            // concatenation unit sees a well-formed (if abandoned) block.
            cc_eop_d = 1'b1;
            ovf_d    = 1'b1;
            if (sel_eop) begin
              cmpl_valid_d = 1'b1;
              cmpl_id_d    = grant_q;
              cmpl_bits_d  = MAX_LIM;
              cmpl_ovf_d   = 1'b1;
              acc_d        = PREFIX_INIT;
              ovf_d        = 1'b0;
              state_d      = ST_IDLE;
            end else begin
              state_d = ST_SINK;
            end
          end else begin
            cc_eop_d = sel_eop;
            acc_d    = sum;
            if (sel_eop) begin
              cmpl_valid_d = 1'b1;
              cmpl_id_d    = grant_q;
              cmpl_bits_d  = sum;
              cmpl_ovf_d   = 1'b0;
              acc_d        = PREFIX_INIT;
              state_d      = ST_IDLE;
            end
          end
        end
      end

      ST_SINK: begin
        req_ready_o[grant_q] = 1'b1;
        if (sel_valid && sel_eop) begin
          cmpl_valid_d = 1'b1;
          cmpl_id_d    = grant_q;
          cmpl_bits_d  = MAX_LIM;
          cmpl_ovf_d   = ovf_q;
          acc_d        = PREFIX_INIT;
          ovf_d        = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready is combinational, so hold it low while reset is asserted.
    if (!rst_n) begin
      req_ready_o = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      rr_q         <= 1'b0;
      acc_q        <= PREFIX_INIT;
      ovf_q        <= 1'b0;
      first_q      <= 1'b0;
      cc_valid_o   <= 1'b0;
      cc_sop_o     <= 1'b0;
      cc_eop_o     <= 1'b0;
      cc_data_o    <= '0;
      cc_size_o    <= '0;
      cmpl_valid_o <= 1'b0;
      cmpl_id_o    <= 1'b0;
      cmpl_bits_o  <= '0;
      cmpl_ovf_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      first_q      <= first_d;
      cc_valid_o   <= cc_valid_d;
      cc_sop_o     <= cc_sop_d;
      cc_eop_o     <= cc_eop_d;
      cc_data_o    <= cc_data_d;
      cc_size_o    <= cc_size_d;
      cmpl_valid_o <= cmpl_valid_d;
      cmpl_id_o    <= cmpl_id_d;
      cmpl_bits_o  <= cmpl_bits_d;
      cmpl_ovf_o   <= cmpl_ovf_d;
    end
  end

endmodule

// File: tb/tb_aidc_lite_concat_sched.sv
// tb_aidc_lite_concat_sched
// Directed bench for aidc_lite_concat_sched. Drivers push the expected cc
// beat / completion (tagged with the cycle it must appear in) into
// scoreboards, and a negedge monitor pops and compares whatever the DUT
// presents.
module tb_aidc_lite_concat_sched;
  import aidc_lite_pkg::*;

  localparam int DW = 66;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic           v0 = 1'b0, v1 = 1'b0;
  logic           s0 = 1'b0, s1 = 1'b0;
  logic           e0 = 1'b0, e1 = 1'b0;
  logic [DW-1:0]  d0 = '0, d1 = '0;
  logic [6:0]     z0 = '0, z1 = '0;

  logic [1:0]     req_valid_i, req_ready_o, req_sop_i, req_eop_i;
  logic [DW-1:0]  req_data_i [2];
  logic [6:0]     req_size_i [2];
  logic           cc_valid_o, cc_sop_o, cc_eop_o;
  logic [DW-1:0]  cc_data_o;
  logic [6:0]     cc_size_o;
  logic           cmpl_valid_o, cmpl_id_o, cmpl_ovf_o;
  logic [10:0]    cmpl_bits_o;

  assign req_valid_i   = {v1, v0};
  assign req_sop_i     = {s1, s0};
  assign req_eop_i     = {e1, e0};
  assign req_data_i[0] = d0;
  assign req_data_i[1] = d1;
  assign req_size_i[0] = z0;
  assign req_size_i[1] = z1;

  aidc_lite_concat_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_sop_i    (req_sop_i),
    .req_eop_i    (req_eop_i),
    .req_data_i   (req_data_i),
    .req_size_i   (req_size_i),
    .cc_valid_o   (cc_valid_o),
    .cc_sop_o     (cc_sop_o),
    .cc_eop_o     (cc_eop_o),
    .cc_data_o    (cc_data_o),
    .cc_size_o    (cc_size_o),
    .cmpl_valid_o (cmpl_valid_o),
    .cmpl_id_o    (cmpl_id_o),
    .cmpl_bits_o  (cmpl_bits_o),
    .cmpl_ovf_o   (cmpl_ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int            stamp;
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic [6:0]    size;
  } cc_exp_t;

  typedef struct {
    int          stamp;
    logic        id;
    logic [10:0] bits;
    logic        ovf;
  } cm_exp_t;

  cc_exp_t ccq[$];
  cm_exp_t cmq[$];
  cc_exp_t ce;
  cm_exp_t me;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compares every beat and completion the DUT shows.
  always @(negedge clk) begin
    if (cc_valid_o === 1'b1) begin
      if (ccq.size() == 0) begin
        checkOutput("cc_unexpected", 1, 0);
      end else begin
        ce = ccq.pop_front();
        checkOutput("cc_cycle", cyc, ce.stamp);
        checkOutput("cc_sop", cc_sop_o, ce.sop);
        checkOutput("cc_eop", cc_eop_o, ce.eop);
        checkOutput("cc_data", cc_data_o, ce.data);
        checkOutput("cc_size", cc_size_o, ce.size);
      end
    end
    if (cmpl_valid_o === 1'b1) begin
      if (cmq.size() == 0) begin
        checkOutput("cmpl_unexpected", 1, 0);
      end else begin
        me = cmq.pop_front();
        checkOutput("cmpl_cycle", cyc, me.stamp);
        checkOutput("cmpl_id", cmpl_id_o, me.id);
        checkOutput("cmpl_bits", cmpl_bits_o, me.bits);
        checkOutput("cmpl_ovf", cmpl_ovf_o, me.ovf);
      end
    end
  end

  // Present one beat on a requester, wait (bounded) for it to be accepted,
  // then queue the hand-computed response due one cycle after acceptance.
  task automatic applyStimulus(input bit id, input bit sop, input bit eop,
                               input logic [DW-1:0] data, input logic [6:0] size,
                               input bit exp_fwd, input bit exp_sop, input bit exp_eop,
                               input bit exp_cmpl, input logic [10:0] exp_bits,
                               input bit exp_ovf);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    if (id == 1'b0) begin
      v0 = 1'b1; s0 = sop; e0 = eop; d0 = data; z0 = size;
    end else begin
      v1 = 1'b1; s1 = sop; e1 = eop; d1 = data; z1 = size;
    end
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = (req_ready_o[id] === 1'b1);
      @(posedge clk);
      n++;
    end
    #1;
    if (id == 1'b0) v0 = 1'b0;
    else v1 = 1'b0;
    if (!acc) begin
      checkOutput("accept_timeout", 0, 1);
    end else begin
      if (exp_fwd) ccq.push_back('{cyc, exp_sop, exp_eop, data, size});
      if (exp_cmpl) cmq.push_back('{cyc, id, exp_bits, exp_ovf});
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cc_valid", cc_valid_o, 0);
    checkOutput("rst_cc_sop", cc_sop_o, 0);
    checkOutput("rst_cc_eop", cc_eop_o, 0);
    checkOutput("rst_cc_data", cc_data_o, 0);
    checkOutput("rst_cc_size", cc_size_o, 0);
    checkOutput("rst_cmpl_valid", cmpl_valid_o, 0);
    checkOutput("rst_cmpl_id", cmpl_id_o, 0);
    checkOutput("rst_cmpl_bits", cmpl_bits_o, 0);
    checkOutput("rst_cmpl_ovf", cmpl_ovf_o, 0);
    checkOutput("rst_ready", req_ready_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    doReset();

    // Round-robin from reset: req0, req1, then req0 wins the next contest.
    fork
      begin
        applyStimulus(1'b0, 1'b1, 1'b1, 66'h0_0000_0000_0000_0A01, 7'd10, 1, 1, 1, 1, 11'd12, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 66'h0_0000_0000_0000_0A02, 7'd20, 1, 1, 1, 1, 11'd22, 0);
      end
      begin
        applyStimulus(1'b1, 1'b1, 1'b1, 66'h0_0000_0000_0000_0B01, 7'd8, 1, 1, 1, 1, 11'd10, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 66'h0_0000_0000_0000_0B02, 7'd4, 1, 1, 1, 1, 11'd6, 0);
      end
    join
    idleCycles(3);

    // Three-beat block 6+34+34 on req0: 2+74 = 76 bits.
    applyStimulus(1'b0, 1'b1, 1'b0, 66'h3_0000_0000_0000_1111, 7'd6,  1, 1, 0, 0, 11'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 66'h2_AAAA_0000_0000_2222, 7'd34, 1, 0, 0, 0, 11'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 66'h1_5555_0000_0000_3333, 7'd34, 1, 0, 1, 1, 11'd76, 0);
    idleCycles(2);

    // Single-beat block on req1: sop and eop together, 2+10 = 12 bits.
    applyStimulus(1'b1, 1'b1, 1'b1, 66'h0_DEAD_BEEF_0000_0001, 7'd10, 1, 1, 1, 1, 11'd12, 0);
    idleCycles(2);

    // First beat without sop still opens the block; 5-cycle valid gap mid-block.
    applyStimulus(1'b0, 1'b0, 1'b0, 66'h0_0000_0000_0000_4001, 7'd20, 1, 1, 0, 0, 11'd0, 0);
    idleCycles(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 66'h0_0000_0000_0000_4002, 7'd20, 1, 0, 0, 0, 11'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 66'h0_0000_0000_0000_4003, 7'd20, 1, 0, 1, 1, 11'd62, 0);
    idleCycles(2);

    // Overflow on req1: 15x34 lands exactly on 512, 16th beat overflows and
    // closes the cc block, 17th (eop) is sunk and completes with ovf.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, (i == 1), 1'b0, 66'(64'h5000 + i), 7'd34,
                    1, (i == 1), (i == 16), 0, 11'd0, 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 66'h0_0000_0000_0000_5011, 7'd34, 0, 0, 0, 1, 11'd512, 1);
    idleCycles(2);

    // Reset mid-block: three beats forwarded, no completion afterwards.
    applyStimulus(1'b0, 1'b1, 1'b0, 66'h0_0000_0000_0000_6001, 7'd10, 1, 1, 0, 0, 11'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 66'h0_0000_0000_0000_6002, 7'd10, 1, 0, 0, 0, 11'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 66'h0_0000_0000_0000_6003, 7'd10, 1, 0, 0, 0, 11'd0, 0);
    doReset();

    // Fresh block after reset counts from the prefix again: 2+10+10 = 22.
    applyStimulus(1'b0, 1'b1, 1'b0, 66'h0_0000_0000_0000_7001, 7'd10, 1, 1, 0, 0, 11'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 66'h0_0000_0000_0000_7002, 7'd10, 1, 0, 1, 1, 11'd22, 0);
    idleCycles(5);

    checkOutput("cc_queue_drained", ccq.size(), 0);
    checkOutput("cmpl_queue_drained", cmq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aidc_lite_concat_sched.md
AIDC_LITE_CONCAT_SCHED -- requirements
Module: aidc_lite_concat_sched

Interface
REQ-001 Parameter DATA_SIZE, default 66, width of code beat data.
REQ-002 Parameter MAX_BITS, default 512, maximum compressed block size in bits, prefix included.
REQ-003 Parameter PREFIX_BITS, default 2, prefix bits preloaded per block.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid_i[1:0]  input  2  per-requester beat valid.
REQ-007 req_ready_o[1:0]  output  2  per-requester beat accept.
REQ-008 req_sop_i[1:0], req_eop_i[1:0]  input  2 each  per-requester block start/end.
REQ-009 req_data_i[2][DATA_SIZE-1:0]  input  2x66  code bits, MSB-aligned.
REQ-010 req_size_i[2][6:0]  input  2x7  valid bits in beat, 0..66.
REQ-011 cc_valid_o, cc_sop_o, cc_eop_o  output  1 each  beat to concatenation unit, no backpressure.
REQ-012 cc_data_o  output  66  forwarded data.
REQ-013 cc_size_o  output  7  forwarded size.
REQ-014 cmpl_valid_o  output  1  one-cycle block-completion pulse.
REQ-015 cmpl_id_o  output  1  requester owning completed block.
REQ-016 cmpl_bits_o  output  11  final block size in bits.
REQ-017 cmpl_ovf_o  output  1  block exceeded MAX_BITS; raw fallback required.

Function
REQ-018 States SHALL be IDLE, XFER, SINK; block-granular grant, sop to eop.
REQ-019 In IDLE, req_ready_o SHALL be 0; if any req_valid_i, grant SHALL latch and go XFER next cycle.
REQ-020 Arbitration SHALL be round-robin: both valid -> grant rr pointer; pointer SHALL flip to the non-granted requester on each grant.
REQ-021 In XFER, req_ready_o SHALL be 1 only for the granted requester; a beat is accepted when valid & ready.
REQ-022 Accepted beats SHALL appear on cc_* exactly one cycle later (registered); cc_valid_o SHALL be 0 otherwise.
REQ-023 First accepted beat of a grant SHALL drive cc_sop_o=1 regardless of req_sop_i.
REQ-024 Accumulator acc (11 bits) SHALL start at PREFIX_BITS and add req_size_i per accepted beat.
REQ-025 Accepted beat with eop and acc+size <= MAX_BITS: forward with cc_eop_o=1, cmpl pulse next cycle with bits=acc+size, ovf=0, return IDLE.
REQ-026 Accepted beat with acc+size > MAX_BITS: forward with cc_eop_o forced 1, set ovf; if beat had eop -> cmpl and IDLE, else -> SINK.
REQ-027 In SINK, ready SHALL stay 1 for granted requester, beats SHALL be discarded (no cc_valid_o); on eop beat, cmpl pulse next cycle with bits=MAX_BITS, ovf=1, return IDLE.
REQ-028 Single-beat block (sop&eop) SHALL be legal; cc_sop_o and cc_eop_o both 1.
REQ-029 Completion pulse SHALL coincide with the cc_eop_o cycle (non-SINK) and never overlap another pulse.
REQ-030 Returning to IDLE SHALL reset acc to PREFIX_BITS and ovf to 0; minimum per-block cost is one arbitration bubble.
REQ-031 Non-granted requester inputs SHALL be ignored; its valid may stay high indefinitely.

Reset
REQ-032 During rst_n=0: state IDLE, rr pointer 0, acc=PREFIX_BITS, ovf 0, all outputs 0.
REQ-033 Reset mid-block SHALL abandon the block with no completion pulse; cc_* SHALL go 0 the cycle after reset sampled.

Structure
REQ-034 State enum, MAX_BITS, PREFIX_BITS, DATA_SIZE defaults SHALL live in shared package aidc_lite_pkg.
REQ-035 No sub-module; round-robin pick inline, single always_comb plus single always_ff.

Verification
REQ-036 Req0 block sizes 6,34,34 (sop..eop) -> cc beats one cycle delayed, cmpl id 0, bits 76, ovf 0.
REQ-037 Both valid from reset -> req0 block served first, then req1; next contest grants req0 again.
REQ-038 Req1 sends 16 beats of 34 -> beat 15 (acc 2+510=512 ok), beat 16 (546) forwarded with cc_eop_o=1, then SINK; cmpl bits 512, ovf 1, id 1.
REQ-039 Single beat sop&eop size 10 -> cc_sop_o=cc_eop_o=1, cmpl bits 12.
REQ-040 rst_n low after 3 beats of block -> no cmpl, outputs 0; new block after reset gives bits from 2.
REQ-041 Granted requester drops valid mid-block for 5 cycles -> no cc_valid_o gaps filled, acc unchanged, block completes correctly.
